// File: rtl/gpmc_initiator.sv
// GPMC asynchronous address/data-multiplexed 16-bit bus initiator.
// Turns single-word valid/ready requests into registered CS/ADV/OE/WE strobe sequences.
module gpmc_initiator #(
    parameter int unsigned ADDR_CYC   = 2,
    parameter int unsigned ACCESS_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned IDLE_CYC   = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WE,
    input  logic [15:0] REQ_ADDR,
    input  logic [15:0] REQ_WDATA,
    input  logic [1:0]  REQ_BE,
    output logic        DONE,
    output logic [15:0] RD_DATA,
    inout  wire  [15:0] GPMC_AD,
    output logic        GPMC_CS,
    output logic        GPMC_ADV,
    output logic        GPMC_OE,
    output logic        GPMC_WE,
    output logic        GPMC_BE0,
    output logic        GPMC_BE1,
    output logic        GPMC_DIR
);

    localparam logic [3:0] AddrLoad   = 4'(ADDR_CYC - 1);
    localparam logic [3:0] AccessLoad = 4'(ACCESS_CYC - 1);
    localparam logic [3:0] HoldLoad   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] IdleLoad   = 4'(IDLE_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAhold,
        StAccess,
        StHold,
        StRecov
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Request fields captured at acceptance
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;

    logic        cs_q, cs_d;
    logic        adv_q, adv_d;
    logic        oe_q, oe_d;
    logic        wen_q, wen_d;
    logic        be0_q, be0_d;
    logic        be1_q, be1_d;
    logic        dir_q, dir_d;
    logic        ad_oe_q, ad_oe_d;
    logic [15:0] ad_out_q, ad_out_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [15:0] rd_data_q, rd_data_d;

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            cs_q      <= 1'b1;
            adv_q     <= 1'b1;
            oe_q      <= 1'b1;
            wen_q     <= 1'b1;
            be0_q     <= 1'b1;
            be1_q     <= 1'b1;
            dir_q     <= 1'b0;
            ad_oe_q   <= 1'b0;
            ad_out_q  <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            cs_q      <= cs_d;
            adv_q     <= adv_d;
            oe_q      <= oe_d;
            wen_q     <= wen_d;
            be0_q     <= be0_d;
            be1_q     <= be1_d;
            dir_q     <= dir_d;
            ad_oe_q   <= ad_oe_d;
            ad_out_q  <= ad_out_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state, phase counter, request capture and read sampling
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rd_data_d = rd_data_q;

        case (state_q)
            StIdle: begin
                if (REQ_VALID && ready_q) begin
                    we_d    = REQ_WE;
                    addr_d  = REQ_ADDR;
                    wdata_d = REQ_WDATA;
                    be_d    = REQ_BE;
                    state_d = StAddr;
                    cnt_d   = AddrLoad;
                end
            end
            StAddr: begin
                if (cnt_q == 4'd0) begin
                    state_d = StAhold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAhold: begin
                state_d = StAccess;
                cnt_d   = AccessLoad;
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    // Edge closing the last access cycle captures the responder's data
                    if (!we_q) begin
                        rd_data_d = GPMC_AD;
                    end
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecov;
                    cnt_d   = IdleLoad;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecov: begin
                if (cnt_q == 4'd0) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Bus outputs decoded from the upcoming state so every pin leaves a flop
    always_comb begin
        cs_d     = 1'b1;
        adv_d    = 1'b1;
        oe_d     = 1'b1;
        wen_d    = 1'b1;
        be0_d    = 1'b1;
        be1_d    = 1'b1;
        dir_d    = 1'b0;
        ad_oe_d  = 1'b0;
        ad_out_d = ad_out_q;
        ready_d  = 1'b0;
        done_d   = 1'b0;

        case (state_d)
            StIdle: begin
                ready_d = 1'b1;
            end
            StAddr, StAhold: begin
                cs_d     = 1'b0;
                adv_d    = (state_d != StAddr);
                be0_d    = ~be_d[0];
                be1_d    = ~be_d[1];
                ad_oe_d  = 1'b1;
                ad_out_d = addr_d;
            end
            StAccess: begin
                cs_d  = 1'b0;
                be0_d = ~be_d[0];
                be1_d = ~be_d[1];
                if (we_d) begin
                    wen_d    = 1'b0;
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    oe_d  = 1'b0;
                    dir_d = 1'b1;
                end
            end
            StHold: begin
                cs_d  = 1'b0;
                be0_d = ~be_d[0];
                be1_d = ~be_d[1];
                if (we_d) begin
                    ad_oe_d  = 1'b1;
                    ad_out_d = wdata_d;
                end else begin
                    dir_d = 1'b1;
                end
            end
            StRecov: begin
                done_d = (state_q == StHold);
            end
            default: begin
                ready_d = 1'b0;
            end
        endcase
    end

    assign GPMC_AD   = ad_oe_q ? ad_out_q : 16'hzzzz;
    assign GPMC_CS   = cs_q;
    assign GPMC_ADV  = adv_q;
    assign GPMC_OE   = oe_q;
    assign GPMC_WE   = wen_q;
    assign GPMC_BE0  = be0_q;
    assign GPMC_BE1  = be1_q;
    assign GPMC_DIR  = dir_q;
    assign REQ_READY = ready_q;
    assign DONE      = done_q;
    assign RD_DATA   = rd_data_q;

endmodule
